// File: rtl/seg_scan_ctrl.sv
// Avalon-MM driven 4-digit seven-segment scanner with per-digit blanking and guard gaps.
// Outputs registered (one edge after a state decision); no backpressure, every access completes in one cycle.
module seg_scan_ctrl #(
    parameter int          GUARD_CYCLES = 2,
    parameter logic [15:0] PERIOD_RST   = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [6:0]  segs,
    output logic [3:0]  an
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        GUARD = 2'd2
    } state_t;

    localparam logic [15:0] GUARD_LEN = 16'(GUARD_CYCLES);

    logic [15:0] digits;
    logic        ctrl_en;
    logic [3:0]  blank_mask;
    logic [15:0] period;

    state_t      state, state_nxt;
    logic [1:0]  index, index_nxt;
    logic [15:0] dwell_cnt, dwell_nxt;
    logic [15:0] guard_cnt, guard_nxt;
    logic [15:0] dwell_load;
    logic [3:0]  an_nxt;
    logic [6:0]  segs_nxt;
    logic [3:0]  nibble;
    logic        unused_wd;

    assign unused_wd = ^{writedata[31:16], writedata[3:1]};

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Register file; address 3 is read-only status so writes there fall through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits     <= 16'h0000;
            ctrl_en    <= 1'b0;
            blank_mask <= 4'h0;
            period     <= PERIOD_RST;
        end else if (chipselect && write) begin
            case (address)
                2'd0: digits <= writedata[15:0];
                2'd1: begin
                    ctrl_en    <= writedata[0];
                    blank_mask <= writedata[7:4];
                end
                2'd2: period <= writedata[15:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        readdata = 32'h0;
        if (chipselect) begin
            case (address)
                2'd0:    readdata = {16'h0, digits};
                2'd1:    readdata = {24'h0, blank_mask, 3'b000, ctrl_en};
                2'd2:    readdata = {16'h0, period};
                default: readdata = {29'h0, (state != IDLE), index};
            endcase
        end
    end

    // A zero period still shows each digit for one cycle.
    assign dwell_load = (period == 16'h0) ? 16'd1 : period;

    always_comb begin
        state_nxt = state;
        index_nxt = index;
        dwell_nxt = dwell_cnt;
        guard_nxt = guard_cnt;
        case (state)
            IDLE: begin
                index_nxt = 2'd0;
                if (ctrl_en) begin
                    state_nxt = DWELL;
                    dwell_nxt = dwell_load;
                end
            end
            DWELL: begin
                if (!ctrl_en) begin
                    state_nxt = IDLE;
                    index_nxt = 2'd0;
                end else if (dwell_cnt <= 16'd1) begin
                    if (GUARD_CYCLES > 0) begin
                        state_nxt = GUARD;
                        guard_nxt = GUARD_LEN;
                    end else begin
                        index_nxt = index + 2'd1;
                        dwell_nxt = dwell_load;
                    end
                end else begin
                    dwell_nxt = dwell_cnt - 16'd1;
                end
            end
            GUARD: begin
                if (!ctrl_en) begin
                    state_nxt = IDLE;
                    index_nxt = 2'd0;
                end else if (guard_cnt <= 16'd1) begin
                    state_nxt = DWELL;
                    index_nxt = index + 2'd1;
                    dwell_nxt = dwell_load;
                end else begin
                    guard_nxt = guard_cnt - 16'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                index_nxt = 2'd0;
            end
        endcase
    end

    // Drive outputs from the next state so they switch on the same edge as the state.
    always_comb begin
        an_nxt   = 4'hF;
        segs_nxt = 7'h7F;
        nibble   = digits[{index_nxt, 2'b00} +: 4];
        if (state_nxt == DWELL) begin
            segs_nxt = hex7(nibble);
            if (!blank_mask[index_nxt])
                an_nxt[index_nxt] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            index     <= 2'd0;
            dwell_cnt <= 16'd0;
            guard_cnt <= 16'd0;
            an        <= 4'hF;
            segs      <= 7'h7F;
        end else begin
            state     <= state_nxt;
            index     <= index_nxt;
            dwell_cnt <= dwell_nxt;
            guard_cnt <= guard_nxt;
            an        <= an_nxt;
            segs      <= segs_nxt;
        end
    end

endmodule
